// File: rtl/muldiv_pkg.sv
// ============================================================================
// Module      : muldiv_pkg
// Description : Shared state encoding and constants for the multiply/divide
//               sequencing controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package muldiv_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_MULT_RUN = 3'd1,
        ST_DIV_RUN  = 3'd2,
        ST_WRITE    = 3'd3,
        ST_DONE     = 3'd4,
        ST_EXC      = 3'd5
    } state_t;

    localparam logic HILO_SEL_MULT      = 1'b0;
    localparam logic HILO_SEL_DIV       = 1'b1;
    localparam int   MAX_CYCLES_DEFAULT = 40;
    localparam int   WDOG_CNT_W         = 6;

endpackage

`default_nettype wire

// File: rtl/muldiv_watchdog.sv
// ============================================================================
// Module      : muldiv_watchdog
// Description : Run-state cycle counter; flags the last permitted run cycle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module muldiv_watchdog
    import muldiv_pkg::*;
#(
    parameter int MAX_CYCLES = MAX_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [WDOG_CNT_W-1:0] c_last_cycle = WDOG_CNT_W'(MAX_CYCLES - 1);
    localparam logic [WDOG_CNT_W-1:0] c_cnt_max    = {WDOG_CNT_W{1'b1}};

    logic [WDOG_CNT_W-1:0] r_count;

    // Counter holds 0 in the first run cycle, so cycle N of a run sees N-1.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (enable && (r_count != c_cnt_max)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign expired = enable && (r_count == c_last_cycle);

endmodule

`default_nettype wire

// File: rtl/muldiv_ctrl.sv
// ============================================================================
// Module      : muldiv_ctrl
// Description : Sequences multiply/divide units and HI/LO writeback.
//               Optional watchdog enabled by defining MULDIV_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module muldiv_ctrl
    import muldiv_pkg::*;
#(
    parameter int MAX_CYCLES = MAX_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic op_mult,
    input  logic op_div,
    input  logic mult_stop,
    input  logic div_stop,
    input  logic div_zero,
    output logic mult_init,
    output logic div_init,
    output logic hilo_sel,
    output logic high_load,
    output logic low_load,
    output logic busy,
    output logic done,
    output logic div_zero_exc,
    output logic timeout_exc
);

    if ((MAX_CYCLES < 2) || (MAX_CYCLES > 63)) begin : g_bad_max_cycles
        $error("muldiv_ctrl: MAX_CYCLES must be within 2..63");
    end

    state_t r_state;
    state_t w_next;
    logic   r_mult_init;
    logic   r_div_init;
    logic   r_hilo_sel;
    logic   r_zero_exc;
    logic   r_timeout_exc;
    logic   w_start_mult;
    logic   w_start_div;
    logic   w_zero;
    logic   w_timeout;
    logic   w_expired;

`ifdef MULDIV_TIMEOUT_EN
    logic w_run;

    assign w_run = (r_state == ST_MULT_RUN) || (r_state == ST_DIV_RUN);

    muldiv_watchdog #(
        .MAX_CYCLES (MAX_CYCLES)
    ) u_watchdog (
        .clk     (clk),
        .reset   (reset),
        .clear   (!w_run),
        .enable  (w_run),
        .expired (w_expired)
    );
`else
    assign w_expired = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_mult_init   <= 1'b0;
            r_div_init    <= 1'b0;
            r_hilo_sel    <= HILO_SEL_MULT;
            r_zero_exc    <= 1'b0;
            r_timeout_exc <= 1'b0;
        end else begin
            r_state       <= w_next;
            r_mult_init   <= w_start_mult;
            r_div_init    <= w_start_div;
            r_zero_exc    <= w_zero;
            r_timeout_exc <= w_timeout;
            if (w_start_mult) begin
                r_hilo_sel <= HILO_SEL_MULT;
            end else if (w_start_div) begin
                r_hilo_sel <= HILO_SEL_DIV;
            end
        end
    end

    // Completion beats the watchdog when both land on the same cycle.
    always_comb begin
        w_next       = r_state;
        w_start_mult = 1'b0;
        w_start_div  = 1'b0;
        w_zero       = 1'b0;
        w_timeout    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (op_mult) begin
                    w_next       = ST_MULT_RUN;
                    w_start_mult = 1'b1;
                end else if (op_div) begin
                    w_next      = ST_DIV_RUN;
                    w_start_div = 1'b1;
                end
            end
            ST_MULT_RUN: begin
                if (mult_stop) begin
                    w_next = ST_WRITE;
                end else if (w_expired) begin
                    w_next    = ST_EXC;
                    w_timeout = 1'b1;
                end
            end
            ST_DIV_RUN: begin
                if (div_zero) begin
                    w_next = ST_EXC;
                    w_zero = 1'b1;
                end else if (div_stop) begin
                    w_next = ST_WRITE;
                end else if (w_expired) begin
                    w_next    = ST_EXC;
                    w_timeout = 1'b1;
                end
            end
            ST_WRITE: w_next = ST_DONE;
            ST_DONE:  w_next = ST_IDLE;
            ST_EXC:   w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    assign mult_init    = r_mult_init;
    assign div_init     = r_div_init;
    assign hilo_sel     = r_hilo_sel;
    assign high_load    = (r_state == ST_WRITE);
    assign low_load     = (r_state == ST_WRITE);
    assign busy         = (r_state != ST_IDLE);
    assign done         = (r_state == ST_DONE);
    assign div_zero_exc = r_zero_exc;
    assign timeout_exc  = r_timeout_exc;

endmodule

`default_nettype wire

// File: tb/tb_muldiv_ctrl.sv
// ============================================================================
// Module      : tb_muldiv_ctrl
// Description : Scoreboard bench for muldiv_ctrl (honours MULDIV_TIMEOUT_EN).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_muldiv_ctrl;

    localparam int MAXC = 40;
    localparam int ARR  = 4096;

    localparam int EV_MINIT  = 1;
    localparam int EV_DINIT  = 2;
    localparam int EV_LOAD_M = 3;
    localparam int EV_LOAD_D = 4;
    localparam int EV_DONE   = 5;
    localparam int EV_ZEXC   = 6;
    localparam int EV_TEXC   = 7;
    localparam int EV_BADLD  = 8;

    localparam int K_STOP = 0;
    localparam int K_ZERO = 1;
    localparam int K_BOTH = 2;
    localparam int K_NONE = 3;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic op_mult = 1'b0, op_div = 1'b0;
    logic mult_stop = 1'b0, div_stop = 1'b0, div_zero = 1'b0;
    logic mult_init, div_init, hilo_sel, high_load, low_load;
    logic busy, done, div_zero_exc, timeout_exc;

    muldiv_ctrl #(.MAX_CYCLES(MAXC)) dut (
        .clk          (clk),
        .reset        (reset),
        .op_mult      (op_mult),
        .op_div       (op_div),
        .mult_stop    (mult_stop),
        .div_stop     (div_stop),
        .div_zero     (div_zero),
        .mult_init    (mult_init),
        .div_init     (div_init),
        .hilo_sel     (hilo_sel),
        .high_load    (high_load),
        .low_load     (low_load),
        .busy         (busy),
        .done         (done),
        .div_zero_exc (div_zero_exc),
        .timeout_exc  (timeout_exc)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int c;
        int ev;
    } exp_t;

    exp_t sb_q[$];
    bit   exp_busy[ARR];
    bit   exp_hilo[ARR];
    int   checks = 0;
    int   failures = 0;
    bit   mon_en = 1'b0;

    task automatic push_exp(input int c, input int ev);
        exp_t e;
        e.c  = c;
        e.ev = ev;
        sb_q.push_back(e);
    endtask

    task automatic got(input int ev);
        exp_t e;
        checks++;
        if (sb_q.size() == 0) begin
            failures++;
            $display("FAIL event_unexpected cycle=%0d actual_event=%0d required=none", cyc, ev);
        end else begin
            e = sb_q.pop_front();
            if ((e.c != cyc) || (e.ev != ev)) begin
                failures++;
                $display("FAIL event cycle=%0d actual_event=%0d required_event=%0d required_cycle=%0d",
                         cyc, ev, e.ev, e.c);
            end
        end
    endtask

    // Monitor: per-cycle level checks plus event stream against the scoreboard.
    always @(negedge clk) begin
        if (mon_en && (cyc < ARR)) begin
            checks++;
            if (busy !== exp_busy[cyc]) begin
                failures++;
                $display("FAIL busy cycle=%0d actual=%b required=%b", cyc, busy, exp_busy[cyc]);
            end
            checks++;
            if (hilo_sel !== exp_hilo[cyc]) begin
                failures++;
                $display("FAIL hilo_sel cycle=%0d actual=%b required=%b", cyc, hilo_sel, exp_hilo[cyc]);
            end
            if (mult_init)    got(EV_MINIT);
            if (div_init)     got(EV_DINIT);
            if (high_load !== low_load) got(EV_BADLD);
            else if (high_load) got(hilo_sel ? EV_LOAD_D : EV_LOAD_M);
            if (done)         got(EV_DONE);
            if (div_zero_exc) got(EV_ZEXC);
            if (timeout_exc)  got(EV_TEXC);
        end
    end

    task automatic check_all_zero(input string name);
        logic [8:0] v;
        v = {mult_init, div_init, hilo_sel, high_load, low_load,
             busy, done, div_zero_exc, timeout_exc};
        checks++;
        if (v !== 9'd0) begin
            failures++;
            $display("FAIL %s outputs actual=%b required=%b", name, v, 9'd0);
        end
    endtask

    // Idle cycle: no starts, stray stop/zero inputs that must be ignored.
    task automatic tick_idle();
        @(posedge clk);
        #1;
        op_mult   = 1'b0;
        op_div    = 1'b0;
        mult_stop = 1'($urandom_range(0, 1));
        div_stop  = 1'($urandom_range(0, 1));
        div_zero  = 1'($urandom_range(0, 1));
    endtask

    task automatic wait_to(input int c);
        while (cyc < c) tick_idle();
    endtask

    // One operation: start at cycle t, terminating input at cycle s.
    task automatic run_op(input bit is_div, input int t, input int s_in,
                          input int kind, input bit both, output int e);
        int s;
        int k;
        s = s_in;
        k = kind;
`ifndef MULDIV_TIMEOUT_EN
        if (k == K_NONE) begin
            k = K_STOP;
            s = t + 201;
        end
`endif
        if (k == K_NONE) s = t + MAXC;
        e = (k == K_STOP) ? s + 2 : s + 1;

        push_exp(t + 1, is_div ? EV_DINIT : EV_MINIT);
        case (k)
            K_STOP: begin
                push_exp(s + 1, is_div ? EV_LOAD_D : EV_LOAD_M);
                push_exp(s + 2, EV_DONE);
            end
            K_NONE:  push_exp(s + 1, EV_TEXC);
            default: push_exp(s + 1, EV_ZEXC);
        endcase
        for (int c = t + 1; c <= e && c < ARR; c++) exp_busy[c] = 1'b1;
        for (int c = t + 1; c < ARR; c++) exp_hilo[c] = is_div;

        wait_to(t);
        if (is_div) begin
            op_div = 1'b1;
        end else begin
            op_mult = 1'b1;
            op_div  = both;
        end
        for (int c = t + 1; c <= s; c++) begin
            tick_idle();
            op_mult = ($urandom_range(0, 3) == 0);
            op_div  = ($urandom_range(0, 3) == 0) || (c == t + 10);
            if (is_div) begin
                div_stop = 1'b0;
                div_zero = 1'b0;
            end else begin
                mult_stop = 1'b0;
            end
            if (c == s) begin
                case (k)
                    K_STOP: if (is_div) div_stop = 1'b1; else mult_stop = 1'b1;
                    K_ZERO: div_zero = 1'b1;
                    K_BOTH: begin
                        div_zero = 1'b1;
                        div_stop = 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    endtask

    initial begin
        int e;
        int t;
        bit isd;
        int kind;

        #1 reset = 1'b1;
        #1 check_all_zero("reset_initial");
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
        mon_en = 1'b1;

        run_op(1'b0, 10, 43, K_STOP, 1'b0, e);
        run_op(1'b1, e + 3, e + 8, K_ZERO, 1'b0, e);
        run_op(1'b0, e + 1, e + 21, K_STOP, 1'b1, e);
        run_op(1'b1, e + 2, e + 17, K_BOTH, 1'b0, e);
        run_op(1'b1, e + 2, e + 3, K_STOP, 1'b0, e);
        run_op(1'b1, e + 2, 0, K_NONE, 1'b0, e);
        run_op(1'b0, e + 2, 0, K_NONE, 1'b0, e);
        run_op(1'b0, e + 1, e + 1 + MAXC, K_STOP, 1'b0, e);

        // Reset in the middle of a multiply abandons it silently.
        t = e + 2;
        push_exp(t + 1, EV_MINIT);
        for (int c = t + 1; c <= t + 9; c++) exp_busy[c] = 1'b1;
        for (int c = t + 1; c < ARR; c++) exp_hilo[c] = 1'b0;
        wait_to(t);
        op_mult = 1'b1;
        for (int c = t + 1; c <= t + 10; c++) begin
            tick_idle();
            mult_stop = 1'b0;
        end
        #1 reset = 1'b1;
        #1 check_all_zero("reset_midrun");
        #1 reset = 1'b0;
        wait_to(t + 20);
        mult_stop = 1'b1;
        run_op(1'b1, t + 30, t + 37, K_STOP, 1'b0, e);

        repeat (30) begin
            isd  = 1'($urandom_range(0, 1));
            t    = e + 1 + int'($urandom_range(0, 3));
            kind = isd ? int'($urandom_range(0, 2)) : K_STOP;
            run_op(isd, t, t + int'($urandom_range(1, MAXC)), kind,
                   isd ? 1'b0 : 1'($urandom_range(0, 1)), e);
        end

        wait_to(e + 5);
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain actual_pending=%0d required=0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL sim_time_limit actual=expired required=finished");
        $fatal(1, "time limit");
    end

endmodule

`default_nettype wire
